// File: rtl/sine_stream_ctrl.sv
// Burst sequencer for the sine generator: holds it in reset while idle, paces its
// enable at a programmable rate and forwards each sample into the async FIFO write port.
module sine_stream_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [DIV_WIDTH-1:0]  rate_div_i,
  input  logic [LEN_WIDTH-1:0]  burst_len_i,
  output logic                  gen_n_rst_o,
  output logic                  gen_enable_o,
  input  logic [DATA_WIDTH-1:0] gen_sample_i,
  input  logic                  fifo_full_i,
  output logic                  fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0] fifo_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  late_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  rate_m1_q, rate_m1_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [LEN_WIDTH-1:0]  burst_len_q, burst_len_d;
  logic [LEN_WIDTH-1:0]  sample_cnt_q, sample_cnt_d;
  logic                  pend_q, pend_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  gen_n_rst_q, gen_n_rst_d;
  logic                  gen_enable_q, gen_enable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  late_q, late_d;

  logic                  wr_c;
  logic                  hold_accept_c;
  logic                  capture_c;
  logic                  slot_free_c;
  logic                  tick_c;
  logic [LEN_WIDTH-1:0]  sample_cnt_inc_c;

  // pend holds the generator's current output until it has moved into the hold
  // register; a new enable is only allowed when that move happens this cycle.
  assign wr_c             = hold_valid_q && !fifo_full_i;
  assign hold_accept_c    = !hold_valid_q || !fifo_full_i;
  assign capture_c        = pend_q && hold_accept_c;
  assign slot_free_c      = !pend_q || hold_accept_c;
  assign tick_c           = (div_cnt_q == rate_m1_q);
  assign sample_cnt_inc_c = sample_cnt_q + LEN_WIDTH'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      rate_m1_q    <= '0;
      div_cnt_q    <= '0;
      burst_len_q  <= '0;
      sample_cnt_q <= '0;
      pend_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      gen_n_rst_q  <= 1'b0;
      gen_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      late_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rate_m1_q    <= rate_m1_d;
      div_cnt_q    <= div_cnt_d;
      burst_len_q  <= burst_len_d;
      sample_cnt_q <= sample_cnt_d;
      pend_q       <= pend_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      gen_n_rst_q  <= gen_n_rst_d;
      gen_enable_q <= gen_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      late_q       <= late_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rate_m1_d    = rate_m1_q;
    div_cnt_d    = div_cnt_q;
    burst_len_d  = burst_len_q;
    sample_cnt_d = sample_cnt_q;
    gen_enable_d = 1'b0;
    done_d       = 1'b0;
    late_d       = late_q;
    pend_d       = gen_enable_q || (pend_q && !capture_c);
    hold_valid_d = capture_c || (hold_valid_q && !wr_c);
    hold_data_d  = capture_c ? gen_sample_i : hold_data_q;

    unique case (state_q)
      ST_IDLE: begin
        // The start edge itself issues enable #1, so the burst begins at phase 0.
        if (start_i) begin
          rate_m1_d    = (rate_div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(1)
                                                      : rate_div_i - DIV_WIDTH'(1);
          burst_len_d  = burst_len_i;
          sample_cnt_d = LEN_WIDTH'(1);
          div_cnt_d    = '0;
          late_d       = 1'b0;
          pend_d       = 1'b0;
          hold_valid_d = 1'b0;
          gen_enable_d = 1'b1;
          state_d      = (burst_len_i == LEN_WIDTH'(1)) ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_FLUSH;
        end else if (tick_c) begin
          if (slot_free_c) begin
            gen_enable_d = 1'b1;
            div_cnt_d    = '0;
            sample_cnt_d = sample_cnt_inc_c;
            if ((burst_len_q != '0) && (sample_cnt_inc_c == burst_len_q)) begin
              state_d = ST_FLUSH;
            end
          end else begin
            late_d = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
      end
      ST_FLUSH: begin
        if (!pend_d && !hold_valid_d) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    gen_n_rst_d = (state_d != ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign gen_n_rst_o  = gen_n_rst_q;
  assign gen_enable_o = gen_enable_q;
  assign fifo_wr_en_o = wr_c;
  assign fifo_wdata_o = hold_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign late_o       = late_q;

endmodule

// File: tb/tb_sine_stream_ctrl.sv
// Self-checking bench for sine_stream_ctrl: a ROM-backed generator model, directed
// bursts and randomized-backpressure bursts checked against schedule/order rules.
module tb_sine_stream_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned VW = 16;
  localparam int unsigned LW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          stop_i;
  logic [VW-1:0] rate_div_i;
  logic [LW-1:0] burst_len_i;
  logic          gen_n_rst_o;
  logic          gen_enable_o;
  logic [DW-1:0] gen_sample_i;
  logic          fifo_full_i;
  logic          fifo_wr_en_o;
  logic [DW-1:0] fifo_wdata_o;
  logic          busy_o;
  logic          done_o;
  logic          late_o;

  sine_stream_ctrl #(.DATA_WIDTH(DW), .DIV_WIDTH(VW), .LEN_WIDTH(LW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .rate_div_i   (rate_div_i),
    .burst_len_i  (burst_len_i),
    .gen_n_rst_o  (gen_n_rst_o),
    .gen_enable_o (gen_enable_o),
    .gen_sample_i (gen_sample_i),
    .fifo_full_i  (fifo_full_i),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_wdata_o (fifo_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .late_o       (late_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Generator model: output steps through the ROM on each enable and holds otherwise.
  logic [DW-1:0] rom [0:255];
  logic [7:0]    gen_idx;
  always @(posedge clk_i) begin
    if (!gen_n_rst_o) begin
      gen_idx      <= 8'd0;
      gen_sample_i <= '0;
    end else if (gen_enable_o) begin
      gen_sample_i <= rom[gen_idx];
      gen_idx      <= gen_idx + 8'd1;
    end
  end

  int tests = 0;
  int fails = 0;

  int            en_q[$];
  int            wr_cyc_q[$];
  logic [DW-1:0] wr_dat_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // bp_mode: 0 none, 1 five-cycle full window after the first write, 2 random full.
  task automatic run_burst(input string name, input int rate, input int len,
                           input int stop_after, input int bp_mode, input int exp_late);
    int reff, nexp, s, bp_from, done_cyc;
    bit got_done, stop_pending, stopped, flush_start, bp_armed, spacing_ok;
    reff = (rate < 2) ? 2 : rate;
    nexp = (len == 0) ? stop_after : len;
    en_q.delete(); wr_cyc_q.delete(); wr_dat_q.delete();
    got_done = 0; stop_pending = 0; stopped = 0; flush_start = 0; bp_armed = 0;
    bp_from = -100; done_cyc = -1;

    @(negedge clk_i);
    start_i     = 1'b1;
    rate_div_i  = VW'(rate);
    burst_len_i = LW'(len);
    fifo_full_i = 1'b0;
    s = cyc;

    for (int k = 0; k < 800 && !got_done; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      stop_i  = 1'b0;
      if (stop_pending) begin
        stop_i = 1'b1; stop_pending = 0; stopped = 1; flush_start = 1;
      end else if (flush_start) begin
        start_i = 1'b1; flush_start = 0;
      end
      case (bp_mode)
        1:       fifo_full_i = (cyc >= bp_from) && (cyc < bp_from + 5);
        2:       fifo_full_i = ($urandom_range(0, 3) == 0);
        default: fifo_full_i = 1'b0;
      endcase
      #1;
      if (k == 0) begin
        chk({name, " busy_at_start"}, 32'(busy_o), 1);
        chk({name, " gen_n_rst_at_start"}, 32'(gen_n_rst_o), 1);
        chk({name, " enable_at_start"}, 32'(gen_enable_o), 1);
        chk({name, " late_cleared"}, 32'(late_o), 0);
      end
      if (gen_enable_o) en_q.push_back(cyc);
      if (fifo_wr_en_o) begin
        wr_cyc_q.push_back(cyc);
        wr_dat_q.push_back(fifo_wdata_o);
      end
      if (done_o) begin
        got_done = 1; done_cyc = cyc;
      end
      if (stop_after > 0 && !stopped && !stop_pending && en_q.size() == stop_after)
        stop_pending = 1;
      if (bp_mode == 1 && !bp_armed && wr_cyc_q.size() == 1) begin
        bp_armed = 1; bp_from = cyc + 1;
      end
    end
    fifo_full_i = 1'b0;
    start_i     = 1'b0;
    stop_i      = 1'b0;

    chk({name, " done_seen"}, 32'(got_done), 1);
    chk({name, " busy_at_done"}, 32'(busy_o), 0);
    chk({name, " gen_n_rst_at_done"}, 32'(gen_n_rst_o), 0);
    chk({name, " enable_count"}, 32'(en_q.size()), 32'(nexp));
    chk({name, " write_count"}, 32'(wr_dat_q.size()), 32'(nexp));
    for (int i = 0; i < wr_dat_q.size(); i++)
      chk($sformatf("%s data[%0d]", name, i), 32'(wr_dat_q[i]), 32'(rom[i]));
    if (exp_late >= 0) chk({name, " late"}, 32'(late_o), 32'(exp_late));

    if (bp_mode == 0) begin
      for (int i = 0; i < en_q.size(); i++)
        chk($sformatf("%s enable_cyc[%0d]", name, i), 32'(en_q[i] - s), 32'(1 + i * reff));
      for (int i = 0; i < wr_cyc_q.size() && i < en_q.size(); i++)
        chk($sformatf("%s write_lat[%0d]", name, i), 32'(wr_cyc_q[i] - en_q[i]), 2);
      if (en_q.size() > 0)
        chk({name, " done_lat"}, 32'(done_cyc - en_q[en_q.size() - 1]), 3);
    end else begin
      spacing_ok = 1;
      for (int i = 1; i < en_q.size(); i++)
        if (en_q[i] - en_q[i - 1] < reff) spacing_ok = 0;
      chk({name, " enable_spacing"}, 32'(spacing_ok), 1);
    end

    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      #1;
      chk({name, " idle_done_low"}, 32'(done_o), 0);
      chk({name, " idle_no_activity"}, 32'(gen_enable_o | fifo_wr_en_o | busy_o), 0);
    end
  endtask

  initial begin
    int rate, len, s;
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; fifo_full_i = 1'b0;
    rate_div_i = '0; burst_len_i = '0;
    for (int i = 0; i < 256; i++) rom[i] = DW'($urandom);

    repeat (3) @(negedge clk_i);
    #1;
    chk("rst gen_n_rst", 32'(gen_n_rst_o), 0);
    chk("rst gen_enable", 32'(gen_enable_o), 0);
    chk("rst wr_en", 32'(fifo_wr_en_o), 0);
    chk("rst wdata", 32'(fifo_wdata_o), 0);
    chk("rst busy", 32'(busy_o), 0);
    chk("rst done", 32'(done_o), 0);
    chk("rst late", 32'(late_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_burst("basic", 4, 8, 0, 0, 0);
    run_burst("clamp", 0, 5, 0, 0, 0);
    run_burst("backpressure", 2, 6, 0, 1, 1);
    run_burst("restart", 3, 4, 0, 0, 0);
    run_burst("stop", 3, 0, 3, 0, 0);
    run_burst("len1", 5, 1, 0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      rate = $urandom_range(0, 6);
      len  = $urandom_range(1, 10);
      run_burst($sformatf("rand%0d", r), rate, len, 0, 2, -1);
    end

    // Reset in the middle of a burst while a sample sits in the hold register.
    @(negedge clk_i);
    start_i = 1'b1; rate_div_i = VW'(4); burst_len_i = LW'(20); fifo_full_i = 1'b1;
    s = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
    while (cyc < s + 6) @(negedge clk_i);
    rst_i = 1'b1; fifo_full_i = 1'b0;
    #1;
    chk("midrst gen_n_rst", 32'(gen_n_rst_o), 0);
    chk("midrst gen_enable", 32'(gen_enable_o), 0);
    chk("midrst wr_en", 32'(fifo_wr_en_o), 0);
    chk("midrst wdata", 32'(fifo_wdata_o), 0);
    chk("midrst busy", 32'(busy_o), 0);
    chk("midrst late", 32'(late_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      #1;
      chk("post_rst quiet", 32'(gen_enable_o | fifo_wr_en_o | busy_o | done_o), 0);
    end

    run_burst("after_rst", 2, 3, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
